// File: rtl/mux_pkg.sv
// Shared types and helpers for the one-bit mux and its upstream select sequencer.
package mux_pkg;

  typedef enum logic [0:0] {IDLE, SHIFT} seq_state_t;

  // Select width for an n-input mux; a 2:1 (or degenerate) mux still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_generic_1bit.sv
// Generic N:1 one-bit mux; out-of-range select codes yield 0.
module mux_generic_1bit
  import mux_pkg::*;
#(
  parameter int NUM_OF_INPUTS = 5,
  localparam int SEL_W = sel_width(NUM_OF_INPUTS)
) (
  input  logic [NUM_OF_INPUTS-1:0] a,
  input  logic [SEL_W-1:0]         sel,
  output logic                     f
);

  always_comb begin
    f = 1'b0;
    for (int i = 0; i < NUM_OF_INPUTS; i++) begin
      if (sel == SEL_W'(i)) f = a[i];
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Captures a parallel word and scans it out one bit per accepted beat by stepping
// the select of a mux_generic_1bit instance.
module mux_sel_sequencer
  import mux_pkg::*;
#(
  parameter int NUM_OF_INPUTS = 5,
  parameter bit MSB_FIRST = 1'b0,
  localparam int SEL_W = sel_width(NUM_OF_INPUTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OF_INPUTS-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_bit,
  output logic                     out_last,
  output logic [SEL_W-1:0]         sel,
  output logic [NUM_OF_INPUTS-1:0] data_q,
  output logic                     busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, but in_ready depends on out_ready so the
  // next word can load on the last beat of the current one without a bubble.

  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(NUM_OF_INPUTS - 1);
  localparam logic [SEL_W-1:0] FIRST   = MSB_FIRST ? IDX_MAX : '0;
  localparam logic [SEL_W-1:0] LAST    = MSB_FIRST ? '0 : IDX_MAX;

  seq_state_t state;

  logic beat;
  logic load;

  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign out_last  = busy & (sel == LAST);
  assign beat      = out_valid & out_ready;
  assign in_ready  = (state == IDLE) | (beat & out_last);
  assign load      = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      data_q <= '0;
      sel    <= '0;
    end else if (load) begin
      state  <= SHIFT;
      data_q <= in_data;
      sel    <= FIRST;
    end else if (beat) begin
      // The last beat either reloads (handled above) or drops back to IDLE,
      // so sel never steps past LAST.
      if (out_last) state <= IDLE;
      else if (MSB_FIRST) sel <= sel - SEL_W'(1);
      else sel <= sel + SEL_W'(1);
    end
  end

  mux_generic_1bit #(
    .NUM_OF_INPUTS(NUM_OF_INPUTS)
  ) u_mux (
    .a  (data_q),
    .sel(sel),
    .f  (out_bit)
  );

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: an LSB-first and an MSB-first instance share stimulus.
module tb_mux_sel_sequencer;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] in_data = '0;

  logic         a_in_ready, a_out_valid, a_out_bit, a_out_last, a_busy;
  logic [2:0]   a_sel;
  logic [N-1:0] a_data_q;
  logic         b_in_ready, b_out_valid, b_out_bit, b_out_last, b_busy;
  logic [2:0]   b_sel;
  logic [N-1:0] b_data_q;

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:0] exp_q[$];
  logic [0:0] exp_m_q[$];

  always #5 clk = ~clk;

  mux_sel_sequencer #(.NUM_OF_INPUTS(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_bit(a_out_bit), .out_last(a_out_last), .sel(a_sel),
    .data_q(a_data_q), .busy(a_busy)
  );

  mux_sel_sequencer #(.NUM_OF_INPUTS(N), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_bit(b_out_bit), .out_last(b_out_last), .sel(b_sel),
    .data_q(b_data_q), .busy(b_busy)
  );

  typedef struct {
    logic         iv;
    logic [N-1:0] d;
    logic         ordy;
    logic         ov;
    logic         ir;
    logic         last;
    logic [2:0]   sel;
    logic         bitv;
    logic [N-1:0] dq;
    logic [2:0]   msel;
    logic         mbit;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic iv, logic [N-1:0] d, logic ordy, logic ov, logic ir,
                              logic last, logic [2:0] s, logic bt, logic [N-1:0] dq,
                              logic [2:0] ms, logic mb);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.ov = ov; v.ir = ir; v.last = last;
    v.sel = s; v.bitv = bt; v.dq = dq; v.msel = ms; v.mbit = mb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge, then score beats that will transfer.
  task automatic drive(input logic iv, input logic [N-1:0] d, input logic ordy);
    @(negedge clk);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    #1;
    if (a_out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_lsb_empty", 1, 0);
      else check("sb_lsb_bit", {31'd0, a_out_bit}, {31'd0, exp_q.pop_front()});
    end
    if (b_out_valid && out_ready) begin
      if (exp_m_q.size() == 0) check("sb_msb_empty", 1, 0);
      else check("sb_msb_bit", {31'd0, b_out_bit}, {31'd0, exp_m_q.pop_front()});
    end
    if (in_valid && a_in_ready) begin
      for (int i = 0; i < N; i++) exp_q.push_back(d[i]);
      for (int i = N - 1; i >= 0; i--) exp_m_q.push_back(d[i]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ov"}, {31'd0, a_out_valid}, 0);
    check({tag, "_busy"}, {31'd0, a_busy}, 0);
    check({tag, "_last"}, {31'd0, a_out_last}, 0);
    check({tag, "_sel"}, {29'd0, a_sel}, 0);
    check({tag, "_dq"}, {27'd0, a_data_q}, 0);
    check({tag, "_m_ov"}, {31'd0, b_out_valid}, 0);
    check({tag, "_m_sel"}, {29'd0, b_sel}, 0);
  endtask

  initial begin
    tbl[0]  = mk(1, 5'b10110, 1, 0, 1, 0, 0, 0, 5'b00000, 0, 0);
    tbl[1]  = mk(0, 5'b10110, 1, 1, 0, 0, 0, 0, 5'b10110, 4, 1);
    tbl[2]  = mk(0, 5'b10110, 1, 1, 0, 0, 1, 1, 5'b10110, 3, 0);
    tbl[3]  = mk(0, 5'b10110, 1, 1, 0, 0, 2, 1, 5'b10110, 2, 1);
    tbl[4]  = mk(0, 5'b10110, 1, 1, 0, 0, 3, 0, 5'b10110, 1, 1);
    tbl[5]  = mk(0, 5'b10110, 1, 1, 1, 1, 4, 1, 5'b10110, 0, 0);
    tbl[6]  = mk(0, 5'b10110, 1, 0, 1, 0, 4, 1, 5'b10110, 0, 0);
    tbl[7]  = mk(1, 5'b01101, 1, 0, 1, 0, 4, 1, 5'b10110, 0, 0);
    tbl[8]  = mk(0, 5'b01101, 1, 1, 0, 0, 0, 1, 5'b01101, 4, 0);
    tbl[9]  = mk(0, 5'b01101, 1, 1, 0, 0, 1, 0, 5'b01101, 3, 1);
    tbl[10] = mk(1, 5'b10010, 0, 1, 0, 0, 2, 1, 5'b01101, 2, 1);
    tbl[11] = mk(1, 5'b10010, 0, 1, 0, 0, 2, 1, 5'b01101, 2, 1);
    tbl[12] = mk(1, 5'b10010, 0, 1, 0, 0, 2, 1, 5'b01101, 2, 1);
    tbl[13] = mk(0, 5'b10010, 1, 1, 0, 0, 2, 1, 5'b01101, 2, 1);
    tbl[14] = mk(0, 5'b10010, 1, 1, 0, 0, 3, 1, 5'b01101, 1, 0);
    tbl[15] = mk(1, 5'b00001, 1, 1, 1, 1, 4, 0, 5'b01101, 0, 1);
    tbl[16] = mk(0, 5'b00001, 1, 1, 0, 0, 0, 1, 5'b00001, 4, 0);
    tbl[17] = mk(0, 5'b00001, 1, 1, 0, 0, 1, 0, 5'b00001, 3, 0);
    tbl[18] = mk(0, 5'b00001, 1, 1, 0, 0, 2, 0, 5'b00001, 2, 0);
    tbl[19] = mk(0, 5'b00001, 1, 1, 0, 0, 3, 0, 5'b00001, 1, 0);
    tbl[20] = mk(0, 5'b00001, 1, 1, 1, 1, 4, 0, 5'b00001, 0, 1);
    tbl[21] = mk(0, 5'b00001, 1, 0, 1, 0, 4, 0, 5'b00001, 0, 1);

    // Asynchronous reset asserted between clock edges.
    #2 reset = 1'b1;
    #1 check_reset_values("rst_async");
    check("rst_in_ready", {31'd0, a_in_ready}, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rel_in_ready", {31'd0, a_in_ready}, 1);
    check("rel_m_in_ready", {31'd0, b_in_ready}, 1);

    // Basic scan, backpressure with ignored in_data, back-to-back words.
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check($sformatf("v%0d_ov", i), {31'd0, a_out_valid}, {31'd0, tbl[i].ov});
      check($sformatf("v%0d_busy", i), {31'd0, a_busy}, {31'd0, tbl[i].ov});
      check($sformatf("v%0d_ir", i), {31'd0, a_in_ready}, {31'd0, tbl[i].ir});
      check($sformatf("v%0d_last", i), {31'd0, a_out_last}, {31'd0, tbl[i].last});
      check($sformatf("v%0d_sel", i), {29'd0, a_sel}, {29'd0, tbl[i].sel});
      check($sformatf("v%0d_bit", i), {31'd0, a_out_bit}, {31'd0, tbl[i].bitv});
      check($sformatf("v%0d_dq", i), {27'd0, a_data_q}, {27'd0, tbl[i].dq});
      check($sformatf("v%0d_m_ov", i), {31'd0, b_out_valid}, {31'd0, tbl[i].ov});
      check($sformatf("v%0d_m_ir", i), {31'd0, b_in_ready}, {31'd0, tbl[i].ir});
      check($sformatf("v%0d_m_last", i), {31'd0, b_out_last}, {31'd0, tbl[i].last});
      check($sformatf("v%0d_m_sel", i), {29'd0, b_sel}, {29'd0, tbl[i].msel});
      check($sformatf("v%0d_m_bit", i), {31'd0, b_out_bit}, {31'd0, tbl[i].mbit});
      check($sformatf("v%0d_m_dq", i), {27'd0, b_data_q}, {27'd0, tbl[i].dq});
    end

    // Reset in the middle of a word, at sel=3.
    drive(1, 5'b10110, 1);
    check("mid_load_ir", {31'd0, a_in_ready}, 1);
    for (int i = 0; i < 3; i++) drive(0, 5'b10110, 1);
    drive(0, 5'b10110, 0);
    check("mid_pre_sel", {29'd0, a_sel}, 3);
    check("mid_pre_last", {31'd0, a_out_last}, 0);
    #2 reset = 1'b1;
    #1 check_reset_values("rst_mid");
    exp_q.delete();
    exp_m_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1 check("mid_rel_ir", {31'd0, a_in_ready}, 1);

    // Full word after the aborted scan.
    drive(1, 5'b11111, 1);
    check("ones_load_ir", {31'd0, a_in_ready}, 1);
    for (int i = 0; i < N; i++) begin
      drive(0, 5'b00000, 1);
      check($sformatf("ones%0d_ov", i), {31'd0, a_out_valid}, 1);
      check($sformatf("ones%0d_sel", i), {29'd0, a_sel}, i);
      check($sformatf("ones%0d_bit", i), {31'd0, a_out_bit}, 1);
      check($sformatf("ones%0d_last", i), {31'd0, a_out_last}, (i == N - 1) ? 1 : 0);
      check($sformatf("ones%0d_m_sel", i), {29'd0, b_sel}, N - 1 - i);
      check($sformatf("ones%0d_m_last", i), {31'd0, b_out_last}, (i == N - 1) ? 1 : 0);
    end
    drive(0, 5'b00000, 1);
    check("ones_idle_ov", {31'd0, a_out_valid}, 0);
    check("ones_idle_ir", {31'd0, a_in_ready}, 1);
    check("sb_lsb_left", exp_q.size(), 0);
    check("sb_msb_left", exp_m_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream sequencing stage for the generic N:1 one-bit mux, mux_generic_1bit.
- Accepts a parallel word of NUM_OF_INPUTS bits over a valid/ready handshake and holds it in a register.
- Steps the mux select through every input index, one per accepted output beat.
- Presents the result as a serial bit stream with valid/ready/last. Used wherever a captured parallel vector must be scanned out bit by bit.

Parameters:
- NUM_OF_INPUTS, 5, word width and number of mux inputs; legal range is 2 or more.
- MSB_FIRST, 0, scan order: 0 scans index 0 up to N-1; 1 scans index N-1 down to 0.
- SEL_W, $clog2(NUM_OF_INPUTS), derived select width (localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  NUM_OF_INPUTS  parallel word to scan.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  downstream consumes out_bit this cycle.
- out_bit  out  1  currently selected bit, data_q[sel].
- out_last  out  1  current beat is the final index of the word.
- sel  out  SEL_W  current select index, driven to the mux.
- data_q  out  NUM_OF_INPUTS  captured word, driven to the mux a input.
- busy  out  1  state is SHIFT.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. All flops clear immediately on reset assertion.
- Reset values: state=IDLE, data_q=0, sel=0, out_valid=0, out_last=0, busy=0, in_ready=1 (once reset is released).
- Start/end index: FIRST = 0 and LAST = N-1 when MSB_FIRST=0. FIRST = N-1 and LAST = 0 when MSB_FIRST=1.
- out_bit: purely combinational from data_q and sel through an internal mux_generic_1bit instance. No added latency.
- out_valid and busy are registered and equal (state==SHIFT).
- out_last = busy & (sel==LAST).
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is a combinational path from out_ready to in_ready; it is intentional and gives zero-bubble back-to-back words.
- Load: when in_valid & in_ready, then on the next edge data_q <= in_data, sel <= FIRST, state <= SHIFT. First out_valid appears 1 cycle after acceptance.
- IDLE state: out_valid=0. sel and data_q hold their last values. Leaves IDLE on load.
- SHIFT state with out_valid & out_ready & !out_last: sel steps by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
- SHIFT state with out_valid & out_ready & out_last:
  - if in_valid is also high, a new load occurs and the state stays SHIFT;
  - otherwise state <= IDLE.
- Stall: out_valid & !out_ready holds sel, data_q and out_bit stable. in_data changes during SHIFT are ignored.
- sel never leaves the range 0..N-1. No wrap past LAST: stepping past LAST is impossible because that beat causes load or IDLE.
- Non-power-of-two N: sel codes N..2^SEL_W-1 are never driven.
- Reset mid-word: the scan is aborted and no partial out_last is produced. The first in_valid after reset release is accepted from IDLE.
- in_valid in SHIFT other than on the last accepted beat: in_ready=0, so no capture occurs and upstream must hold its word.

Decomposition:
- Shared package mux_pkg holds:
  - function sel_width(n) returning $clog2(n), with a minimum of 1;
  - typedef enum logic [0:0] {IDLE, SHIFT} seq_state_t.
- Sub-module: one instance of mux_generic_1bit with NUM_OF_INPUTS passed through, a=data_q, sel=sel, f=out_bit.
- Everything else (sequencer FSM, index counter, word register) stays flat in this module.

Test Plan:
- Reset then idle: reset pulsed high asynchronously between clock edges -> all outputs immediately at reset values; in_ready=1 after release.
- Basic scan, N=5, MSB_FIRST=0: in_data=5'b10110 accepted, out_ready=1 -> out_bit sequence 0,1,1,0,1 on sel 0..4; out_last only on the 5th beat; return to IDLE next cycle.
- MSB-first: MSB_FIRST=1, in_data=5'b10110 -> out_bit 1,0,1,1,0 on sel 4,3,2,1,0; out_last with sel=0.
- Backpressure: out_ready low for 3 cycles at sel=2 -> sel, out_bit and data_q stable for those cycles; no beat lost or duplicated; in_data toggled during the stall is ignored.
- Back-to-back: second word 5'b00001 presented with in_valid on the last beat of the first word -> in_ready=1 that cycle; sel=0 on the next cycle with out_valid held high; zero bubble between words.
- Reset mid-word: reset asserted at sel=3 -> out_valid=0 and sel=0 immediately; no out_last seen; next word 5'b11111 scans all five beats correctly.
